// File: rtl/pe_read_controller_pkg.sv
// Shared accelerator defaults, used by pe_read_controller and read_address_generator alike.
package pe_read_controller_pkg;

  localparam int unsigned PipeDepthDefault   = 2;
  localparam int unsigned WinCntWidthDefault = 8;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth single-bit delay line with a synchronous flush.
module valid_delay_line #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [Depth-1:0] shift_q, shift_d;

  always_comb begin
    shift_d    = shift_q << 1;
    shift_d[0] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign dout = shift_q[Depth-1];

endmodule

// File: rtl/pe_read_controller.sv
// Read-side controller of a PE: sequences a convolution pass against the address generator
// and flags each finished window's partial sum once it leaves the MAC pipeline.
module pe_read_controller
  import pe_read_controller_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH    = PipeDepthDefault,
  parameter int unsigned WIN_CNT_WIDTH = WinCntWidthDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     ifmap_valid,
  input  logic                     end_valid_in,
  input  logic                     psum_full,
  input  logic                     at_end_data,
  input  logic                     co_pipe,
  output logic                     read_data,
  output logic                     stall,
  output logic                     clr_addr,
  output logic                     valid_end,
  output logic                     busy,
  output logic                     done,
  output logic                     psum_valid,
  output logic [WIN_CNT_WIDTH-1:0] win_count
);

  typedef enum logic [2:0] {StIdle, StClear, StWait, StRun, StDrain, StDone} state_e;

  localparam int unsigned DrainWidth = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [WIN_CNT_WIDTH-1:0] WinOne = WIN_CNT_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [DrainWidth-1:0]    drain_q, drain_d;
  logic [WIN_CNT_WIDTH-1:0] win_count_q, win_count_d;
  logic                     accept;
  logic                     last_drain;

  assign accept     = (state_q == StRun) && !stall;
  assign last_drain = (drain_q == DrainWidth'(PIPE_DEPTH - 1));

  always_comb begin
    state_d     = state_q;
    drain_d     = '0;
    win_count_d = win_count_q;
    read_data   = 1'b0;
    stall       = 1'b0;
    clr_addr    = 1'b0;
    valid_end   = 1'b0;
    done        = 1'b0;
    busy        = (state_q != StIdle);
    case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        clr_addr    = 1'b1;
        win_count_d = '0;
        state_d     = StWait;
      end
      StWait: begin
        valid_end = end_valid_in;
        if (ifmap_valid && end_valid_in) state_d = StRun;
      end
      StRun: begin
        read_data = 1'b1;
        stall     = psum_full || !ifmap_valid;
        valid_end = end_valid_in;
        if (!stall && co_pipe) begin
          if (win_count_q != '1) win_count_d = win_count_q + WinOne;
          if (at_end_data) state_d = StDrain;
        end
      end
      StDrain: begin
        // Hold off DONE until the last window's psum has left the pipeline.
        drain_d = drain_q + DrainWidth'(1);
        if (last_drain) begin
          drain_d = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      drain_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      drain_q     <= '0;
      win_count_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      win_count_q <= win_count_d;
    end
  end

  valid_delay_line #(
    .Depth(PIPE_DEPTH)
  ) u_psum_delay (
    .clk  (clk),
    .rst  (rst),
    .clear(abort),
    .din  (accept && co_pipe),
    .dout (psum_valid)
  );

  assign win_count = win_count_q;

endmodule

// File: tb/tb_pe_read_controller.sv
// Randomised bench for pe_read_controller: an address-generator model drives the handshake and a
// scoreboard predicts psum_valid and done timing from the accepted reads.
module tb_pe_read_controller;
  import pe_read_controller_pkg::*;

  localparam int unsigned PD = PipeDepthDefault;
  localparam int unsigned WW = WinCntWidthDefault;
  localparam int FS = 4, STRIDE = 3, SD = 2, ED = 14;
  localparam int NWIN = (ED - FS + 1 - SD) / STRIDE + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic ifmap_valid = 1'b0, end_valid_in = 1'b0, psum_full = 1'b0;
  logic at_end_data, co_pipe;
  logic read_data, stall, clr_addr, valid_end, busy, done, psum_valid;
  logic [WW-1:0] win_count;

  int checks = 0, errors = 0, cyc = 0;
  int psum_q[$];
  int done_q[$];
  int psum_seen = 0, clr_seen = 0;
  int elem = 0, wstart = SD;
  logic exp_pv, exp_dn;

  pe_read_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .ifmap_valid (ifmap_valid),
    .end_valid_in(end_valid_in),
    .psum_full   (psum_full),
    .at_end_data (at_end_data),
    .co_pipe     (co_pipe),
    .read_data   (read_data),
    .stall       (stall),
    .clr_addr    (clr_addr),
    .valid_end   (valid_end),
    .busy        (busy),
    .done        (done),
    .psum_valid  (psum_valid),
    .win_count   (win_count)
  );

  always #5 clk = ~clk;

  // Address generator: windows of FS elements, stepping STRIDE, from SD until one ends at ED.
  assign co_pipe     = (elem == FS - 1);
  assign at_end_data = (wstart + FS - 1 == ED);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_addr) begin
      elem   <= 0;
      wstart <= SD;
    end else if (read_data && !stall) begin
      if (elem == FS - 1) begin
        elem   <= 0;
        wstart <= wstart + STRIDE;
      end else begin
        elem <= elem + 1;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      exp_pv = (psum_q.size() > 0) && (psum_q[0] == cyc);
      chk("psum_valid", psum_valid, exp_pv);
      if (exp_pv) void'(psum_q.pop_front());
      if (psum_valid) psum_seen++;
      exp_dn = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("done", done, exp_dn);
      if (exp_dn) void'(done_q.pop_front());
      if (clr_addr) clr_seen++;
      if (read_data) begin
        chk("stall", stall, psum_full || !ifmap_valid);
        chk("valid_end", valid_end, end_valid_in);
        if (!(psum_full || !ifmap_valid) && co_pipe) begin
          psum_q.push_back(cyc + PD);
          if (at_end_data) done_q.push_back(cyc + PD + 1);
        end
      end
      if (abort) begin
        while (psum_q.size() > 0 && psum_q[$] > cyc) void'(psum_q.pop_back());
        done_q.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_data"}, read_data, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_clr_addr"}, clr_addr, 0);
    chk({tag, "_valid_end"}, valid_end, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_psum_valid"}, psum_valid, 0);
    chk({tag, "_win_count"}, win_count, 0);
  endtask

  task automatic begin_pass(input logic ifv);
    psum_seen    = 0;
    clr_seen     = 0;
    ifmap_valid  = ifv;
    end_valid_in = 1'b1;
    psum_full    = 1'b0;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  task automatic finish_pass(input string tag, input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rnd && read_data) begin
        ifmap_valid = ($urandom_range(3) != 0);
        psum_full   = ($urandom_range(3) == 0);
      end
      step();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    ifmap_valid = 1'b1;
    psum_full   = 1'b0;
    chk({tag, "_done_reached"}, ok, 1);
    if (ok) begin
      chk({tag, "_win_count"}, win_count, NWIN);
      chk({tag, "_psum_pulses"}, psum_seen, NWIN);
      chk({tag, "_clr_pulses"}, clr_seen, 1);
    end
    step();
    chk({tag, "_idle_after"}, busy, 0);
  endtask

  task automatic wait_win(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (win_count == WW'(n)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("wait_win_count", ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [WW-1:0] wc;
    // Reset
    #2;
    chk_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_reset_busy", busy, 0);

    // Contention: abort beats start
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("contention_busy", busy, 0);
    step();
    chk("contention_busy2", busy, 0);

    // Nominal pass
    begin_pass(1'b1);
    finish_pass("nominal", 1'b0);

    // Backpressure: five stalled cycles mid-window
    begin_pass(1'b1);
    wait_win(1);
    step();
    wc = win_count;
    psum_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_read_data", read_data, 1);
      chk("bp_stall", stall, 1);
      chk("bp_win_frozen", win_count, wc);
      step();
    end
    chk("bp_win_after", win_count, wc);
    psum_full = 1'b0;
    finish_pass("backpressure", 1'b0);

    // Abort after two windows, then restart
    begin_pass(1'b1);
    wait_win(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_psum", psum_valid, 0);
    for (int i = 0; i < int'(PD) + 1; i++) begin
      step();
      chk("abort_psum_quiet", psum_valid, 0);
      chk("abort_no_done", done, 0);
    end
    begin_pass(1'b1);
    step();
    chk("restart_win_cleared", win_count, 0);
    chk("restart_wait_no_read", read_data, 0);
    finish_pass("restart", 1'b0);

    // WAIT hold with ifmap_valid low
    begin_pass(1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("wait_read_data", read_data, 0);
      chk("wait_busy", busy, 1);
      step();
    end
    ifmap_valid = 1'b1;
    #1;
    chk("wait_rise_read", read_data, 0);
    step();
    chk("wait_run_read", read_data, 1);
    finish_pass("wait_hold", 1'b0);

    // Asynchronous reset while draining
    begin_pass(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (read_data && !stall && co_pipe && at_end_data) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("drain_reached", ok, 1);
    step();
    chk("drain_busy", busy, 1);
    chk("drain_no_read", read_data, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    psum_q.delete();
    done_q.delete();
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_release_busy", busy, 0);
    chk("reset_release_win", win_count, 0);

    // Randomised passes
    for (int p = 0; p < 4; p++) begin
      begin_pass(1'b1);
      finish_pass("random", 1'b1);
    end

    repeat (3) step();
    chk("scoreboard_psum_empty", psum_q.size(), 0);
    chk("scoreboard_done_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_read_controller.md
PE_READ_CONTROLLER -- requirements
Module: pe_read_controller

Interface
REQ-001 The block SHALL have parameter PIPE_DEPTH, default 2, meaning cycles from an accepted read to its partial-sum result.
REQ-002 The block SHALL have parameter WIN_CNT_WIDTH, default 8, meaning the width of the window counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a convolution pass.
REQ-006 The block SHALL have port abort, input, 1, which cancels any pass.
REQ-007 The block SHALL have port ifmap_valid, input, 1, meaning the IFMap scratchpad holds data at the current read address.
REQ-008 The block SHALL have port end_valid_in, input, 1, meaning the end_data register of the address generator is loaded.
REQ-009 The block SHALL have port psum_full, input, 1, the partial-sum buffer backpressure.
REQ-010 The block SHALL have port at_end_data, input, 1, from the address generator: the window at end_data is being read.
REQ-011 The block SHALL have port co_pipe, input, 1, from the address generator: the last filter element of a window is being read.
REQ-012 The block SHALL have the following outputs to the address generator: read_data, stall, clr_addr and valid_end, each 1 bit.
REQ-013 The block SHALL have outputs busy (1), done (1), psum_valid (1) and win_count (WIN_CNT_WIDTH).

Function
REQ-014 The FSM SHALL have the states IDLE, CLEAR, WAIT, RUN, DRAIN and DONE, with state encoding local to the module.
REQ-015 In IDLE, start=1 SHALL move the FSM to CLEAR; start SHALL be ignored in every other state.
REQ-016 In CLEAR, clr_addr=1 SHALL be driven for exactly one cycle, win_count SHALL clear to 0, and the next state SHALL be WAIT.
REQ-017 In WAIT, the FSM SHALL go to RUN when ifmap_valid=1 and end_valid_in=1, and hold otherwise.
REQ-018 In RUN, read_data SHALL be 1 and stall SHALL equal psum_full OR NOT ifmap_valid, both combinational.
REQ-019 A read is accepted when the FSM is in RUN and stall=0; co_pipe=1 on an accepted read SHALL increment win_count, saturating at all-ones.
REQ-020 co_pipe=1 and at_end_data=1 together on an accepted read SHALL move the FSM to DRAIN in the next cycle.
REQ-021 valid_end SHALL equal end_valid_in in WAIT and RUN, and be 0 in all other states.
REQ-022 psum_valid SHALL equal (accepted read AND co_pipe) delayed by exactly PIPE_DEPTH cycles, using a shift register that clears on abort.
REQ-023 In DRAIN, read_data SHALL be 0, and after exactly PIPE_DEPTH cycles the next state SHALL be DONE.
REQ-024 In DONE, done=1 SHALL be driven for one cycle, the next state SHALL be IDLE, and win_count SHALL hold until the next CLEAR.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 abort=1 in any state SHALL force IDLE in the next cycle and clear the psum_valid pipeline; done SHALL NOT pulse.
REQ-027 abort and start in the same cycle in IDLE SHALL resolve to abort winning, leaving the FSM in IDLE.
REQ-028 All outputs other than read_data, stall, clr_addr, valid_end, busy and done SHALL be registered; those six are decoded from state.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, win_count=0 and the drain counter to 0, and clear the psum_valid pipeline.
REQ-030 During reset, all outputs SHALL be 0.
REQ-031 Reset asserted mid-RUN SHALL abandon the pass with no done pulse.

Structure
REQ-032 PIPE_DEPTH default and the WIN_CNT_WIDTH default SHALL live in the shared accelerator package, shared with read_address_generator.
REQ-033 The psum_valid delay line SHALL be a sub-module named valid_delay_line, parameterised by depth.

Verification
REQ-034 Scenario (nominal): start with ifmap_valid=1, end_valid_in=1, and the address-generator model using filter_size=4, stride=3, start_data=2, end_data=14 -> clr_addr pulses once, 4 windows complete, win_count=4, 4 psum_valid pulses each 2 cycles after co_pipe, done one cycle after DRAIN completes.
REQ-035 Scenario (backpressure): psum_full=1 for 5 cycles mid-window -> stall=1 for those 5 cycles, win_count frozen, no psum_valid generated for the stalled cycles.
REQ-036 Scenario (abort): abort pulses in RUN after 2 windows -> IDLE next cycle, no done, psum_valid pipeline empty, and a restart clears win_count to 0.
REQ-037 Scenario (reset): rst asserted asynchronously in DRAIN -> outputs 0 with no clock edge required, and the FSM is in IDLE after release.
REQ-038 Scenario (WAIT hold): ifmap_valid=0 for 10 cycles after CLEAR -> the FSM stays in WAIT with read_data=0, then enters RUN the cycle after ifmap_valid rises.
REQ-039 Scenario (contention): start and abort together in IDLE -> busy stays 0.
